// File: rtl/usb_serial_tx_buffer.sv
// usb_serial_tx_buffer
//   Byte buffer in front of the usb_serial tx port. User logic streams bytes
//   in freely; bytes only become visible to usb_serial once committed, so the
//   USB side sees whole bursts. A commit happens on a FLUSH_CHAR byte, a flush
//   pulse, an idle timeout, or when the buffer is full.
//
// Ports
//   clk48mhz             48 MHz USB clock, the only clock
//   rst                  synchronous active-high reset, drops all buffered data
//   in_tvalid/in_tready  upstream byte handshake, in_tdata is the byte
//   flush                commit everything accepted so far (incl. this cycle)
//   out_tvalid/out_tready/out_tdata  to usb_serial tx_tvalid/tx_tready/tx_tdata
//   level                bytes accepted and not yet handshaken at the output
//
// Pointers are AW+1 bits with natural wrap:
//   hptr <= rptr <= cptr <= wptr
//   wptr  next RAM slot to write
//   cptr  end of the committed range
//   rptr  next RAM slot to read into the output stage
//   hptr  count of bytes handshaken at the output (drives level)
// Bytes between hptr and rptr live in the read register / output stage, so
// they still occupy RAM slots and are still counted in level.

module usb_serial_tx_buffer #(
  parameter int         AW         = 10,
  parameter int         TIMEOUT    = 48000,
  parameter logic [7:0] FLUSH_CHAR = 8'h0A
) (
  input  logic        clk48mhz,
  input  logic        rst,
  input  logic        in_tvalid,
  output logic        in_tready,
  input  logic [7:0]  in_tdata,
  input  logic        flush,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic [7:0]  out_tdata,
  output logic [AW:0] level
);

  localparam int DEPTH   = 1 << AW;
  localparam int TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef logic [AW:0] ptr_t;

  // one entry of the output stage
  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } slot_t;

  logic [7:0]    mem [DEPTH];
  ptr_t          wptr, cptr, rptr, hptr;
  logic [TW-1:0] tcnt;
  logic          rd_vld;
  logic [7:0]    rd_data;
  slot_t         head, skid;

  logic          acc, pop, full, pending, to_fire, commit, ren;
  ptr_t          wptr_nxt;
  logic [1:0]    occ;

  // ---------------- accept / commit ----------------
  assign level     = wptr - hptr;
  assign full      = (level == ptr_t'(DEPTH));
  assign in_tready = !rst && !full;
  assign acc       = in_tvalid && in_tready;
  assign wptr_nxt  = wptr + ptr_t'(acc);
  assign pending   = (cptr != wptr);

  // Counter sits at TIMEOUT-1 exactly TIMEOUT-1 edges after the last accept,
  // so the commit lands TIMEOUT edges after it.
  assign to_fire = (TIMEOUT != 0) && pending && (tcnt == TW'(TO_LAST));

  // All events collapse into one commit to the post-write pointer; when
  // nothing is uncommitted this rewrites cptr with its own value.
  assign commit = (acc && (in_tdata == FLUSH_CHAR)) || flush || to_fire || full;

  // ---------------- read side ----------------
  assign out_tvalid = head.vld;
  assign out_tdata  = head.data;
  assign pop        = head.vld && out_tready;

  // occ counts bytes already pulled out of RAM (read register + stage).
  // A read issued now lands in the stage one edge later and cannot stall,
  // so issue only if occ stays within the 2-entry stage after that landing.
  // Allowing occ==2 with a pop in flight is what keeps back-to-back output.
  assign occ = 2'(head.vld) + 2'(skid.vld) + 2'(rd_vld);
  assign ren = (rptr != cptr) && ((occ < 2'd2) || ((occ == 2'd2) && pop));

  always_ff @(posedge clk48mhz) begin
    if (rst) begin
      wptr   <= '0;
      cptr   <= '0;
      rptr   <= '0;
      hptr   <= '0;
      tcnt   <= '0;
      rd_vld <= 1'b0;
    end else begin
      wptr   <= wptr_nxt;
      rd_vld <= ren;
      if (commit) cptr <= wptr_nxt;
      if (ren)    rptr <= rptr + ptr_t'(1);
      if (pop)    hptr <= hptr + ptr_t'(1);
      if (acc || commit || !pending || (TIMEOUT == 0))
        tcnt <= '0;
      else
        tcnt <= tcnt + TW'(1);
    end
  end

  // Byte RAM. A write never targets the slot being read: writes need
  // level < DEPTH, which keeps wptr and rptr on different slots.
  always_ff @(posedge clk48mhz) begin
    if (acc) mem[wptr[AW-1:0]] <= in_tdata;
    if (ren) rd_data <= mem[rptr[AW-1:0]];
  end

  // Two-entry output stage: head drives the port and only changes on a pop
  // (or when empty), so out_tdata holds while stalled; skid absorbs the
  // byte that was already in flight from RAM when the stall began.
  always_ff @(posedge clk48mhz) begin
    if (rst) begin
      head <= '0;
      skid <= '0;
    end else begin
      case ({rd_vld, pop})
        2'b11: begin
          if (skid.vld) begin
            head.data <= skid.data;
            skid.data <= rd_data;
          end else begin
            head.data <= rd_data;
          end
        end
        2'b10: begin
          if (!head.vld) head <= '{vld: 1'b1, data: rd_data};
          else           skid <= '{vld: 1'b1, data: rd_data};
        end
        2'b01: begin
          if (skid.vld) begin
            head.data <= skid.data;
            skid.vld  <= 1'b0;
          end else begin
            head.vld  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
